root_seq_ctrl: RTL

Sequencer for the nucleotide random generator: accepts a root-sequence job (length plus A/C/G/T frequencies in parts-per-thousand), validates the frequency set, and drives the generator's probability inputs. It requests one nucleotide at a time, samples the 2-bit result after the generator's fixed latency, and packs nucleotides into words. Packed words are delivered over a valid/ready stream with a last flag. It sits between the host/config logic and the random generator at the front of the simulation datapath.

---
 rtl/root_seq_ctrl_if.sv | 43 ++++
 rtl/root_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/root_seq_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : root_seq_ctrl_if
// Brief    : Job, generator and packed-word stream signals of root_seq_ctrl
// Revision : 1.0
// =============================================================================
interface root_seq_ctrl_if #(
    parameter int LEN_W   = 16,
    parameter int WORD_NT = 16
);
    logic                   start;
    logic [LEN_W-1:0]       seq_len;
    logic [9:0]             freq_a;
    logic [9:0]             freq_c;
    logic [9:0]             freq_g;
    logic [9:0]             freq_t;
    logic [9:0]             cfg_prob_a;
    logic [9:0]             cfg_prob_c;
    logic [9:0]             cfg_prob_g;
    logic [9:0]             cfg_prob_t;
    logic                   rg_req;
    logic [1:0]             rg_nt;
    logic [2*WORD_NT-1:0]   out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport slave (
        input  start, seq_len, freq_a, freq_c, freq_g, freq_t, rg_nt, out_ready,
        output cfg_prob_a, cfg_prob_c, cfg_prob_g, cfg_prob_t, rg_req,
               out_data, out_valid, out_last, busy, done, err
    );

    modport master (
        output start, seq_len, freq_a, freq_c, freq_g, freq_t, rg_nt, out_ready,
        input  cfg_prob_a, cfg_prob_c, cfg_prob_g, cfg_prob_t, rg_req,
               out_data, out_valid, out_last, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/root_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : root_seq_ctrl
// Brief    : Validates a nucleotide frequency job, paces the random generator
//            and packs its 2-bit results into valid/ready output words
// Revision : 1.0
// =============================================================================
module root_seq_ctrl #(
    parameter int LEN_W   = 16,
    parameter int WORD_NT = 16,
    parameter int RG_LAT  = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    root_seq_ctrl_if.slave bus
);
    localparam int c_IDX_W = $clog2(WORD_NT + 1);
    localparam int c_WC_W  = (RG_LAT > 1) ? $clog2(RG_LAT) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_FULL  = c_IDX_W'(WORD_NT);
    localparam logic [c_WC_W-1:0]  c_WC_LAST   = c_WC_W'(RG_LAT - 1);
    localparam logic [11:0]        c_FREQ_SUM  = 12'd1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_total;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_WC_W-1:0]      r_wcnt;
    logic [2*WORD_NT-1:0]   r_pack;
    logic [9:0]             r_cfg_a;
    logic [9:0]             r_cfg_c;
    logic [9:0]             r_cfg_g;
    logic [9:0]             r_cfg_t;
    logic                   r_done;
    logic                   r_err;

    logic [11:0]            w_sum;
    logic                   w_sum_bad;
    logic                   w_len_zero;
    logic                   w_wait_last;
    logic [c_IDX_W-1:0]     w_idx_inc;
    logic                   w_word_full;
    logic                   w_all_done;
    logic                   w_last;
    logic                   w_rg_req;
    logic                   w_out_valid;
    logic                   w_out_last;
    logic                   w_busy;

    // Widened before adding so an out-of-range set can never alias to 1000.
    assign w_sum       = {2'b00, r_cfg_a} + {2'b00, r_cfg_c} + {2'b00, r_cfg_g} + {2'b00, r_cfg_t};
    assign w_sum_bad   = (w_sum != c_FREQ_SUM);
    assign w_len_zero  = (r_len == '0);
    assign w_wait_last = (r_wcnt == c_WC_LAST);
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_word_full = (w_idx_inc == c_IDX_FULL);
    assign w_all_done  = ((r_total + 1'b1) == r_len);
    assign w_last      = (r_total == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rg_req    = 1'b0;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = (w_sum_bad || w_len_zero) ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                w_rg_req    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_last) begin
                    w_state_nxt = (w_word_full || w_all_done) ? ST_OUT : ST_ISSUE;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                w_out_last  = w_last;
                if (bus.out_ready) begin
                    w_state_nxt = w_last ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len   <= '0;
            r_total <= '0;
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_pack  <= '0;
            r_cfg_a <= '0;
            r_cfg_c <= '0;
            r_cfg_g <= '0;
            r_cfg_t <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_len   <= bus.seq_len;
                        r_cfg_a <= bus.freq_a;
                        r_cfg_c <= bus.freq_c;
                        r_cfg_g <= bus.freq_g;
                        r_cfg_t <= bus.freq_t;
                        r_err   <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_sum_bad) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else if (w_len_zero) begin
                        r_done <= 1'b1;
                    end else begin
                        r_idx   <= '0;
                        r_total <= '0;
                        r_pack  <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_wcnt <= '0;
                end
                ST_WAIT: begin
                    if (w_wait_last) begin
                        for (int i = 0; i < WORD_NT; i++) begin
                            if (r_idx == c_IDX_W'(i)) begin
                                r_pack[2*i +: 2] <= bus.rg_nt;
                            end
                        end
                        r_idx   <= w_idx_inc;
                        r_total <= r_total + 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Clearing on every accept keeps unfilled slots of the next word at zero.
                    if (bus.out_ready) begin
                        r_pack <= '0;
                        r_idx  <= '0;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cfg_prob_a = r_cfg_a;
    assign bus.cfg_prob_c = r_cfg_c;
    assign bus.cfg_prob_g = r_cfg_g;
    assign bus.cfg_prob_t = r_cfg_t;
    assign bus.rg_req     = w_rg_req;
    assign bus.out_data   = r_pack;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_out_last;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule
`default_nettype wire
